// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
// Mode encodings and index-width derivation.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int idx_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/result handshake bundle for prio_encoder_rr.
// master drives requests and consumes results; slave is the encoder.
interface prio_encoder_rr_if
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  localparam int IDX_W = idx_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] req;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] onehot;
  logic             none;

  modport master (
    output in_valid, req, mode, out_ready,
    input  in_ready, out_valid, idx, onehot, none
  );

  modport slave (
    input  in_valid, req, mode, out_ready,
    output in_ready, out_valid, idx, onehot, none
  );

endinterface

// File: rtl/prio_enc_core.sv
// Combinational wrap-around priority search.
// Scans downward from start_i, wrapping 0 -> WIDTH-1.
module prio_enc_core #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic             none_o
);

  always_comb begin
    int pos;
    pos    = 0;
    idx_o  = '0;
    none_o = 1'b1;
    // Farthest candidate first, so the nearest hit is the last write.
    for (int k = WIDTH - 1; k >= 0; k--) begin
      pos = int'(start_i) - k;
      if (pos < 0) pos = pos + WIDTH;
      if (req_i[pos]) begin
        idx_o  = IDX_W'(pos);
        none_o = 1'b0;
      end
    end
    onehot_o = none_o ? '0 : (WIDTH'(1) << idx_o);
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder, valid/ready in and out.
// Round-robin policy compiled in only with PRIO_ENC_RR_EN.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  prio_encoder_rr_if.slave bus
);

  localparam int IDX_W = idx_w(WIDTH);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(WIDTH - 1);

  logic             out_valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] onehot_q;
  logic             none_q;

  logic             accept;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] win_idx;
  logic [WIDTH-1:0] win_oh;
  logic             win_none;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;

`ifdef PRIO_ENC_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  always_comb begin
    start = TOP;
    if (bus.mode == MODE_RR)
      start = (ptr_q == '0) ? TOP : ptr_q - 1'b1;
  end

  assign ptr_d = (accept && !win_none) ? win_idx : ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
  assign start = TOP;
`endif

  prio_enc_core #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_core (
    .req_i    (bus.req),
    .start_i  (start),
    .idx_o    (win_idx),
    .onehot_o (win_oh),
    .none_o   (win_none)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      onehot_q    <= '0;
      none_q      <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      idx_q       <= win_idx;
      onehot_q    <= win_oh;
      none_q      <= win_none;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.idx       = idx_q;
  assign bus.onehot    = onehot_q;
  assign bus.none      = none_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr with a per-cycle reference model.
// Round-robin expectations follow PRIO_ENC_RR_EN.
module tb_prio_encoder_rr;

  localparam int W = 8;

`ifdef PRIO_ENC_RR_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  prio_encoder_rr_if #(.WIDTH(W)) bus ();

  prio_encoder_rr #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model
  bit       m_valid = 1'b0;
  int       m_idx   = 0;
  bit       m_none  = 1'b0;
  int       m_ptr   = 0;

  function automatic int winner(input logic [W-1:0] r, input bit rr,
                                input int p);
    if (rr && RR_ON) begin
      for (int k = 1; k <= W; k++)
        if (r[(p - k + 2 * W) % W]) return (p - k + 2 * W) % W;
    end else begin
      for (int b = W - 1; b >= 0; b--)
        if (r[b]) return b;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_none  = 1'b0;
      m_ptr   = 0;
    end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      int w;
      w       = winner(bus.req, bus.mode, m_ptr);
      m_valid = 1'b1;
      m_none  = (w < 0);
      m_idx   = (w < 0) ? 0 : w;
      if (w >= 0) m_ptr = w;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      if (m_valid) begin
        chk("idx", 32'(bus.idx), 32'(m_idx));
        chk("none", 32'(bus.none), 32'(m_none));
        chk("onehot", 32'(bus.onehot),
            m_none ? 32'd0 : (32'd1 << m_idx));
      end
    end
  end

  task automatic send(input logic [W-1:0] r, input logic m,
                      input int e_idx, input logic [W-1:0] e_oh,
                      input logic e_none);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.req      = r;
    bus.mode     = m;
    @(posedge clk);
    #2;
    chk("lit_idx", 32'(bus.idx), 32'(e_idx));
    chk("lit_onehot", 32'(bus.onehot), 32'(e_oh));
    chk("lit_none", 32'(bus.none), 32'(e_none));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.req       = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_idx", 32'(bus.idx), 32'd0);
    chk("rst_onehot", 32'(bus.onehot), 32'd0);
    chk("rst_none", 32'(bus.none), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Walking one, fixed priority
    for (int k = 0; k < W; k++) begin
      logic [W-1:0] v;
      v = W'(1) << k;
      send(v, 1'b0, k, v, 1'b0);
    end
    send(8'b0010_0100, 1'b0, 5, 8'b0010_0000, 1'b0);
    send(8'h00, 1'b0, 0, 8'h00, 1'b1);
    idle();
    @(posedge clk);
    #2;
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // Round-robin from a fresh pointer
    pulse_reset();
    send(8'hFF, 1'b1, 7, 8'h80, 1'b0);
    if (RR_ON) begin
      send(8'hFF, 1'b1, 6, 8'h40, 1'b0);
      send(8'hFF, 1'b1, 5, 8'h20, 1'b0);
    end else begin
      send(8'hFF, 1'b1, 7, 8'h80, 1'b0);
      send(8'hFF, 1'b1, 7, 8'h80, 1'b0);
    end
    send(8'h01, 1'b1, 0, 8'h01, 1'b0);
    send(8'hFF, 1'b1, 7, 8'h80, 1'b0);
    send(8'h00, 1'b1, 0, 8'h00, 1'b1);
    if (RR_ON) send(8'hFF, 1'b1, 6, 8'h40, 1'b0);
    else       send(8'hFF, 1'b1, 7, 8'h80, 1'b0);
    idle();

    // Backpressure: hold result, lose nothing
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(8'h10, 1'b0, 4, 8'h10, 1'b0);
    @(negedge clk);
    bus.req = 8'h03;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #2;
      chk("bp_hold_idx", 32'(bus.idx), 32'd4);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #2;
    chk("bp_new_idx", 32'(bus.idx), 32'd1);
    chk("bp_new_onehot", 32'(bus.onehot), 32'h02);
    idle();
    @(posedge clk);
    #2;
    chk("bp_drain", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with a pending result
    send(8'hFF, 1'b0, 7, 8'h80, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_idx", 32'(bus.idx), 32'd0);
    chk("arst_onehot", 32'(bus.onehot), 32'd0);
    chk("arst_none", 32'(bus.none), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    send(8'hFF, 1'b1, 7, 8'h80, 1'b0);
    if (RR_ON) send(8'hFF, 1'b1, 6, 8'h40, 1'b0);
    else       send(8'hFF, 1'b1, 7, 8'h80, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
